// File: rtl/ball_pkg.sv
// Shared ball definitions: FSM encoding, direction bits, screen geometry.
// Direction bits are chosen so that 1 means "increment the coordinate".
package ball_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      PLAY  = 2'd2
   } state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
   localparam logic DIR_UP    = 1'b0;
   localparam logic DIR_DOWN  = 1'b1;

   localparam int H_RES  = 1024;
   localparam int V_RES  = 768;
   localparam int BALL_R = 10;

   function automatic logic [11:0] step_pos(input logic [11:0] p, input logic inc);
      return inc ? p + 12'd1 : p - 12'd1;
   endfunction

endpackage

// File: rtl/ball_tick_gen.sv
// Programmable-period step strobe: one step every `period` cycles while enabled.
// Latency: step is combinational from the counter; a new period applies at the next reload.
// Backpressure: none; free-running, held at reload while disabled.
module ball_tick_gen #(
   parameter logic [31:0] RESET_PERIOD = 32'd800_000
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] period,
   output logic        step
);

   logic [31:0] cnt_q;

   assign step = enable && (cnt_q == 32'd0);

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         cnt_q <= RESET_PERIOD;
      end else if (!enable || cnt_q == 32'd0) begin
         cnt_q <= period - 32'd1;
      end else begin
         cnt_q <= cnt_q - 32'd1;
      end
   end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball sequencer: serve delay, per-step X/Y motion, paddle and wall bounces, point detection.
// Latency: step effects appear on x_pos/y_pos/score_* one cycle after the step strobe.
// Backpressure: none; paddle hits are latched until the next step so short pulses are kept.
module ball_motion_ctrl #(
   parameter int H_RES      = ball_pkg::H_RES,
   parameter int V_RES      = ball_pkg::V_RES,
   parameter int BALL_R     = ball_pkg::BALL_R,
   parameter int START_X    = 512,
   parameter int START_Y    = 384,
   parameter int TICK_INIT  = 800_000,
   parameter int TICK_MIN   = 200_000,
   parameter int TICK_STEP  = 50_000,
   parameter int SERVE_WAIT = 120
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        start,
   input  logic        paddle_hit_l,
   input  logic        paddle_hit_r,
   output logic [11:0] x_pos,
   output logic [11:0] y_pos,
   output logic        moving,
   output logic        score_l,
   output logic        score_r
);
   import ball_pkg::*;

   localparam logic [11:0] X_MIN     = 12'(BALL_R);
   localparam logic [11:0] X_MAX     = 12'(H_RES - 1 - BALL_R);
   localparam logic [11:0] Y_MIN     = 12'(BALL_R);
   localparam logic [11:0] Y_MAX     = 12'(V_RES - 1 - BALL_R);
   localparam logic [11:0] X_START   = 12'(START_X);
   localparam logic [11:0] Y_START   = 12'(START_Y);
   localparam logic [31:0] P_INIT    = 32'(TICK_INIT);
   localparam logic [31:0] P_MIN     = 32'(TICK_MIN);
   localparam logic [31:0] P_STEP    = 32'(TICK_STEP);
   localparam logic [15:0] SERVE_CNT = 16'(SERVE_WAIT);

   state_t      state_q, state_d;
   logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic [11:0] x_d, y_d;
   logic [31:0] period_q, period_d;
   logic [15:0] serve_q, serve_d;
   logic        hit_l_q, hit_l_d, hit_r_q, hit_r_d;
   logic        score_l_d, score_r_d;
   logic        step, hit_l, hit_r, miss;

   ball_tick_gen #(
      .RESET_PERIOD (P_INIT)
   ) u_tick (
      .pclk   (pclk),
      .reset  (reset),
      .enable (state_q != IDLE),
      .period (period_q),
      .step   (step)
   );

   // A hit arriving in the step cycle itself still counts.
   assign hit_l  = hit_l_q | paddle_hit_l;
   assign hit_r  = hit_r_q | paddle_hit_r;
   assign moving = (state_q == PLAY);

   always_comb begin
      state_d   = state_q;
      dir_x_d   = dir_x_q;
      dir_y_d   = dir_y_q;
      x_d       = x_pos;
      y_d       = y_pos;
      period_d  = period_q;
      serve_d   = serve_q;
      hit_l_d   = hit_l_q;
      hit_r_d   = hit_r_q;
      score_l_d = 1'b0;
      score_r_d = 1'b0;
      miss      = 1'b0;
      case (state_q)
         IDLE: begin
            x_d = X_START;
            y_d = Y_START;
            if (start) begin
               state_d = SERVE;
               serve_d = SERVE_CNT;
            end
         end
         SERVE: begin
            x_d = X_START;
            y_d = Y_START;
            if (step) begin
               serve_d = serve_q - 16'd1;
               if (serve_q == 16'd1) state_d = PLAY;
            end
         end
         PLAY: begin
            hit_l_d = hit_l;
            hit_r_d = hit_r;
            if (step) begin
               hit_l_d = 1'b0;
               hit_r_d = 1'b0;
               if ((dir_y_q == DIR_DOWN && y_pos == Y_MAX) || (dir_y_q == DIR_UP && y_pos == Y_MIN))
                  dir_y_d = ~dir_y_q;
               y_d = step_pos(y_pos, dir_y_d);
               if ((dir_x_q == DIR_LEFT && hit_l) || (dir_x_q == DIR_RIGHT && hit_r)) begin
                  dir_x_d  = ~dir_x_q;
                  x_d      = step_pos(x_pos, dir_x_d);
                  period_d = (period_q >= P_MIN + P_STEP) ? period_q - P_STEP : P_MIN;
               end else if (dir_x_q == DIR_LEFT && x_pos == X_MIN) begin
                  score_r_d = 1'b1;
                  miss      = 1'b1;
               end else if (dir_x_q == DIR_RIGHT && x_pos == X_MAX) begin
                  score_l_d = 1'b1;
                  miss      = 1'b1;
               end else begin
                  x_d = step_pos(x_pos, dir_x_q);
               end
               // dir_x already points at the conceding side, so it is left alone.
               if (miss) begin
                  state_d  = SERVE;
                  serve_d  = SERVE_CNT;
                  x_d      = X_START;
                  y_d      = Y_START;
                  dir_y_d  = dir_y_q;
                  period_d = P_INIT;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         dir_x_q  <= DIR_RIGHT;
         dir_y_q  <= DIR_DOWN;
         x_pos    <= X_START;
         y_pos    <= Y_START;
         period_q <= P_INIT;
         serve_q  <= '0;
         hit_l_q  <= 1'b0;
         hit_r_q  <= 1'b0;
         score_l  <= 1'b0;
         score_r  <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_x_q  <= dir_x_d;
         dir_y_q  <= dir_y_d;
         x_pos    <= x_d;
         y_pos    <= y_d;
         period_q <= period_d;
         serve_q  <= serve_d;
         hit_l_q  <= hit_l_d;
         hit_r_q  <= hit_r_d;
         score_l  <= score_l_d;
         score_r  <= score_r_d;
      end
   end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
Sequencer for ball movement in the game. It owns the step-rate timer, X/Y direction state, paddle-hit bounces, wall bounces, serve delay and point detection, and drives x_pos/y_pos straight to the ball drawing stage. It replaces the separate free-running per-axis movers with one FSM that paddle-collision logic and score logic can both rely on.

Parameters:
H_RES, 1024, horizontal active pixels
V_RES, 768, vertical active pixels
BALL_R, 10, ball half-size in pixels
START_X, 512, serve X position
START_Y, 384, serve Y position
TICK_INIT, 800_000, pclk cycles per 1-pixel step at serve
TICK_MIN, 200_000, fastest allowed step period
TICK_STEP, 50_000, period decrement per paddle hit
SERVE_WAIT, 120, steps the ball is held at START before moving

Ports:
pclk  in  1  pixel clock; all state on rising edge
reset  in  1  asynchronous, active-low; reset==0 forces reset state immediately
start  in  1  one-cycle pulse; leaves IDLE
paddle_hit_l  in  1  left paddle overlaps ball (level or pulse, any cycle)
paddle_hit_r  in  1  right paddle overlaps ball
x_pos  out  12  ball centre X
y_pos  out  12  ball centre Y
moving  out  1  high only in PLAY
score_l  out  1  one-cycle pulse: left player scored
score_r  out  1  one-cycle pulse: right player scored

Behaviour:
- Reset value: state=IDLE, x_pos=START_X, y_pos=START_Y, dir_x=RIGHT, dir_y=DOWN, period=TICK_INIT, tick counter=period, hit latches=0, moving=0, score_l=score_r=0.
- Tick: the down-counter reloads with period-1 when it reaches 0 and asserts step for exactly that cycle, giving one step every period cycles. The counter runs in SERVE and PLAY and is held at reload in IDLE. A change to period takes effect at the next reload.
- Effects of a step are visible on x_pos/y_pos one cycle after step is asserted (registered outputs).
- IDLE: the ball is held at START. start=1 -> SERVE with serve counter=SERVE_WAIT.
- SERVE: the ball is held at START. Each step decrements the serve counter. When the counter reaches 0 on a step -> PLAY. No movement occurs on that step.
- PLAY, on each step:
  - Y: if dir_y=DOWN and y_pos+BALL_R==V_RES-1, or dir_y=UP and y_pos-BALL_R==0, flip dir_y and move 1 in the new direction. Otherwise move 1 in dir_y.
  - X paddle: if dir_x=LEFT and hit_l_latch is set, or dir_x=RIGHT and hit_r_latch is set, flip dir_x, move 1 in the new direction, and set period=max(period-TICK_STEP, TICK_MIN).
  - X wall (no valid hit): at x_pos-BALL_R==0 going LEFT, pulse score_r; at x_pos+BALL_R==H_RES-1 going RIGHT, pulse score_l. Either way, go to SERVE with position=START, period=TICK_INIT, dir_x pointing toward the conceding side, dir_y unchanged. There is no X move on this step.
  - Otherwise move 1 in dir_x.
  - Both hit latches clear on every step.
- Hit latches: set by the paddle_hit inputs in any PLAY cycle and held until the next step, so short collision pulses between steps are not lost. A hit on the side opposite dir_x is ignored.
- Simultaneous events: a paddle hit and the wall boundary on the same step resolve to the hit (bounce, no score). Corner case with X and Y both at boundaries: both axes are handled independently on the same step. start outside IDLE is ignored.
- Arithmetic: positions are 12-bit unsigned. Boundary compares are equality checks on BALL_R-offset values, so position never leaves [BALL_R, RES-1-BALL_R]. period is 32-bit and saturates at TICK_MIN.
- Reset mid-operation: asserting reset returns everything to the reset values asynchronously. No score pulse is emitted.

Decomposition:
- Shared package ball_pkg: state encoding (IDLE, SERVE, PLAY), direction constants (LEFT/RIGHT, UP/DOWN as 1-bit), and screen constants H_RES, V_RES, BALL_R for use by draw and collision blocks.
- Sub-module ball_tick_gen: programmable-period down-counter with inputs pclk, reset, enable, period[31:0] and output step. The FSM, direction and position logic stay in ball_motion_ctrl.

Test Plan:
1. Params TICK_INIT=4, SERVE_WAIT=2. Assert reset, release, pulse start -> moving=0 for 8 cycles, then x_pos goes 512->513 and y_pos 384->385 on the next step.
2. Y bounce with V_RES=768: y_pos reaches 757 going DOWN -> the next step gives y_pos=756 with dir_y=UP.
3. Paddle hit at x_pos=11 going LEFT: a 1-cycle paddle_hit_l between steps -> x_pos=12 on the next step; period 800_000->750_000. Repeat 13 hits -> period held at 200_000.
4. Miss at x_pos=10 going LEFT, no hit -> score_r high for exactly 1 cycle; x_pos=512, y_pos=384, state=SERVE, period=TICK_INIT; the first movement after serve is leftward.
5. paddle_hit_r asserted while moving LEFT at x_pos=10 -> ignored; score_r pulses.
6. Drop reset mid-PLAY, between clock edges -> outputs show the reset values before the next pclk edge. After release, start is required to move again.
